// File: rtl/gpio_pkg.sv
// Shared constants, bus payload type and byte-lane helper for the iomem GPIO bank.
package gpio_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned OFF_W  = 3;

    localparam logic [OFF_W-1:0] OFF_OUT     = 3'd0;
    localparam logic [OFF_W-1:0] OFF_OE      = 3'd1;
    localparam logic [OFF_W-1:0] OFF_IN      = 3'd2;
    localparam logic [OFF_W-1:0] OFF_RISE_EN = 3'd3;
    localparam logic [OFF_W-1:0] OFF_FALL_EN = 3'd4;
    localparam logic [OFF_W-1:0] OFF_STATUS  = 3'd5;

    localparam logic [BUS_W-1:0] RSVD_RDATA = 32'h0000_0000;

    typedef struct packed {
        logic [BUS_W-1:0]  addr;
        logic [BUS_W-1:0]  wdata;
        logic [STRB_W-1:0] wstrb;
    } iomem_req_t;

    // Expand byte strobes into a per-bit write mask.
    function automatic logic [BUS_W-1:0] lane_mask(input logic [STRB_W-1:0] strb);
        logic [BUS_W-1:0] m;
        for (int b = 0; b < int'(STRB_W); b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pad input synchroniser with edge detection; edges are masked until the
// synchroniser and the previous-value flop hold real pin samples.
module gpio_sync
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_c_o,
    output logic [WIDTH-1:0] fall_c_o
);

    localparam int unsigned PRIME_CNT = SYNC_STAGES + 1;
    localparam int unsigned PRIME_W   = $clog2(PRIME_CNT + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [PRIME_W-1:0]                prime_q;
    logic                              primed_c;

    assign primed_c = (prime_q == PRIME_W'(PRIME_CNT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], pin_i};
            prev_q  <= stage_q[SYNC_STAGES-1];
            if (!primed_c) begin
                prime_q <= prime_q + PRIME_W'(1);
            end
        end
    end

    assign sync_o   = stage_q[SYNC_STAGES-1];
    assign rise_c_o = primed_c ? (stage_q[SYNC_STAGES-1] & ~prev_q) : '0;
    assign fall_c_o = primed_c ? (~stage_q[SYNC_STAGES-1] & prev_q) : '0;

endmodule

// File: rtl/iomem_gpio_bank.sv
// Memory-mapped GPIO bank on the iomem bus: output/enable registers, synchronised
// inputs, per-channel rise/fall edge status with write-1-to-clear and a level irq.
module iomem_gpio_bank
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter logic [7:0]  BASE_SEL    = 8'h09,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [STRB_W-1:0] iomem_wstrb,
    input  logic [BUS_W-1:0]  iomem_addr,
    input  logic [BUS_W-1:0]  iomem_wdata,
    output logic [BUS_W-1:0]  iomem_rdata,
    output logic [WIDTH-1:0]  pin_oe,
    output logic [WIDTH-1:0]  pin_do,
    input  logic [WIDTH-1:0]  pin_di,
    output logic              irq
);

    iomem_req_t       req_c;
    logic             accept_c;
    logic [OFF_W-1:0] sel_c;
    logic [BUS_W-1:0] wr_mask_c;
    logic [WIDTH-1:0] wmask_c;
    logic [WIDTH-1:0] wdat_c;
    logic [BUS_W-1:0] rd_val_c;
    logic             unused_bits;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] clr_c;
    logic             ready_q, ready_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] in_w;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .pin_i    (pin_di),
        .sync_o   (in_w),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c)
    );

    assign req_c     = '{addr: iomem_addr, wdata: iomem_wdata, wstrb: iomem_wstrb};
    assign accept_c  = iomem_valid && !ready_q && (req_c.addr[31:24] == BASE_SEL);
    assign sel_c     = req_c.addr[4:2];
    assign wr_mask_c = lane_mask(req_c.wstrb);
    assign wmask_c   = wr_mask_c[WIDTH-1:0];
    assign wdat_c    = req_c.wdata[WIDTH-1:0];
    assign unused_bits = ^{req_c, wr_mask_c};

    // Read mux; channels above WIDTH read as zero via zero-extension.
    always_comb begin
        rd_val_c = RSVD_RDATA;
        case (sel_c)
            OFF_OUT:     rd_val_c = BUS_W'(out_q);
            OFF_OE:      rd_val_c = BUS_W'(oe_q);
            OFF_IN:      rd_val_c = BUS_W'(in_w);
            OFF_RISE_EN: rd_val_c = BUS_W'(rise_en_q);
            OFF_FALL_EN: rd_val_c = BUS_W'(fall_en_q);
            OFF_STATUS:  rd_val_c = BUS_W'(status_q);
            default:     rd_val_c = RSVD_RDATA;
        endcase
    end

    // Next state; a read has an all-zero write mask so the same path serves both.
    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_c     = '0;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        irq_d     = |(status_q & (rise_en_q | fall_en_q));
        if (accept_c) begin
            ready_d = 1'b1;
            rdata_d = rd_val_c;
            case (sel_c)
                OFF_OUT:     out_d     = (out_q & ~wmask_c) | (wdat_c & wmask_c);
                OFF_OE:      oe_d      = (oe_q & ~wmask_c) | (wdat_c & wmask_c);
                OFF_RISE_EN: rise_en_d = (rise_en_q & ~wmask_c) | (wdat_c & wmask_c);
                OFF_FALL_EN: fall_en_d = (fall_en_q & ~wmask_c) | (wdat_c & wmask_c);
                OFF_STATUS:  clr_c     = wdat_c & wmask_c;
                default: ;
            endcase
        end
        // A new edge wins over a concurrent clear of the same bit.
        status_d = (status_q & ~clr_c) | (rise_c & rise_en_q) | (fall_c & fall_en_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign pin_do      = out_q;
    assign pin_oe      = oe_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_gpio_bank.sv
// Directed bench for iomem_gpio_bank: register table plus edge/irq/reset sequences.
module tb_iomem_gpio_bank;
    import gpio_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam logic [7:0]  BASE  = 8'h09;

    logic              clk;
    logic              reset;
    logic              iomem_valid;
    logic              iomem_ready;
    logic [3:0]        iomem_wstrb;
    logic [31:0]       iomem_addr;
    logic [31:0]       iomem_wdata;
    logic [31:0]       iomem_rdata;
    logic [WIDTH-1:0]  pin_oe;
    logic [WIDTH-1:0]  pin_do;
    logic [WIDTH-1:0]  pin_di;
    logic              irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  off;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    iomem_gpio_bank #(
        .WIDTH       (WIDTH),
        .BASE_SEL    (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .pin_oe      (pin_oe),
        .pin_do      (pin_do),
        .pin_di      (pin_di),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ra(input logic [2:0] off);
        return {BASE, 19'h0, off, 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge two cycles later.
    task automatic bus(input logic [2:0] off, input logic [3:0] strb, input logic [31:0] wd,
                       output logic [31:0] rd);
        bit got = 0;
        rd          = '0;
        iomem_valid = 1'b1;
        iomem_addr  = ra(off);
        iomem_wstrb = strb;
        iomem_wdata = wd;
        for (int c = 0; c < 8 && !got; c++) begin
            @(posedge clk); #1;
            if (iomem_ready) begin
                got = 1;
                rd  = iomem_rdata;
            end
        end
        if (!got) check("bus_timeout", 32'(iomem_ready), 32'd1);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(iomem_ready), 32'd0);
        @(negedge clk);
    endtask

    task automatic bus_chk(input string name, input logic [2:0] off, input logic [3:0] strb,
                           input logic [31:0] wd, input logic [31:0] exp);
        logic [31:0] rd;
        bus(off, strb, wd, rd);
        check(name, rd, exp);
    endtask

    initial begin
        bit seen;

        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        iomem_addr  = '0;
        iomem_wdata = '0;
        pin_di      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_pin_oe", 32'(pin_oe), 32'd0);
        check("rst_pin_do", 32'(pin_do), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Register table: writes return the pre-write value.
        vecs[0]  = '{OFF_OUT,     4'b1111, 32'h0000_00A5, 32'h0000_0000};
        vecs[1]  = '{OFF_OE,      4'b0001, 32'h0000_000F, 32'h0000_0000};
        vecs[2]  = '{OFF_OUT,     4'b0000, 32'h0000_0000, 32'h0000_00A5};
        vecs[3]  = '{OFF_OE,      4'b0000, 32'h0000_0000, 32'h0000_000F};
        vecs[4]  = '{OFF_OUT,     4'b0010, 32'h0000_FF00, 32'h0000_00A5};
        vecs[5]  = '{OFF_OUT,     4'b0000, 32'h0000_0000, 32'h0000_00A5};
        vecs[6]  = '{3'd7,        4'b0000, 32'h0000_0000, 32'h0000_0000};
        vecs[7]  = '{3'd6,        4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8]  = '{OFF_IN,      4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9]  = '{OFF_IN,      4'b0000, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{OFF_OE,      4'b1110, 32'hFFFF_FF00, 32'h0000_000F};
        vecs[11] = '{OFF_STATUS,  4'b0000, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 12; i++) begin
            bus_chk($sformatf("vec%0d", i), vecs[i].off, vecs[i].strb, vecs[i].wdata,
                    vecs[i].exp_rdata);
        end
        check("pin_do_a5", 32'(pin_do), 32'h0000_00A5);
        check("pin_oe_0f", 32'(pin_oe), 32'h0000_000F);

        // Foreign base address: no response, no write.
        seen        = 0;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        iomem_wstrb = 4'b1111;
        iomem_wdata = 32'hFFFF_FFFF;
        repeat (5) begin
            @(posedge clk); #1;
            seen |= iomem_ready;
        end
        check("no_ready_other_base", 32'(seen), 32'd0);
        @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        @(negedge clk);
        bus_chk("out_after_foreign", OFF_OUT, 4'b0000, 32'h0, 32'h0000_00A5);

        // Synchroniser latency: a read accepted one edge too early still sees 0.
        pin_di = 8'h02;
        @(negedge clk);
        bus_chk("in_sync_early", OFF_IN, 4'b0000, 32'h0, 32'h0000_0000);
        bus_chk("in_sync_late", OFF_IN, 4'b0000, 32'h0, 32'h0000_0002);

        // Rising edge on channel 0 -> STATUS -> irq, then W1C.
        bus_chk("rise_en_wr", OFF_RISE_EN, 4'b0001, 32'h01, 32'h0);
        pin_di = 8'h03;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("irq_not_early", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("irq_rise", 32'(irq), 32'd1);
        @(negedge clk);
        bus_chk("status_rise", OFF_STATUS, 4'b0000, 32'h0, 32'h0000_0001);
        bus_chk("in_after_rise", OFF_IN, 4'b0000, 32'h0, 32'h0000_0003);
        bus_chk("status_w1c", OFF_STATUS, 4'b0001, 32'h01, 32'h0000_0001);
        check("irq_cleared", 32'(irq), 32'd0);
        bus_chk("status_zero", OFF_STATUS, 4'b0000, 32'h0, 32'h0000_0000);

        // Falling edge on channel 1; disabling the enable keeps STATUS but drops irq.
        bus_chk("fall_en1_wr", OFF_FALL_EN, 4'b0001, 32'h02, 32'h0);
        pin_di = 8'h01;
        repeat (5) @(negedge clk);
        check("irq_fall1", 32'(irq), 32'd1);
        bus_chk("status_fall1", OFF_STATUS, 4'b0000, 32'h0, 32'h0000_0002);
        bus_chk("fall_en_off", OFF_FALL_EN, 4'b0001, 32'h00, 32'h0000_0002);
        check("irq_masked", 32'(irq), 32'd0);
        bus_chk("status_kept", OFF_STATUS, 4'b0000, 32'h0, 32'h0000_0002);
        bus_chk("status_w1c1", OFF_STATUS, 4'b0001, 32'h02, 32'h0000_0002);

        // Channel 7 falls on the very edge a W1C of bit 7 lands: set wins.
        pin_di = 8'h81;
        bus_chk("fall_en7_wr", OFF_FALL_EN, 4'b0001, 32'h80, 32'h0);
        repeat (4) @(negedge clk);
        bus_chk("status_pre7", OFF_STATUS, 4'b0000, 32'h0, 32'h0000_0000);
        pin_di = 8'h01;
        repeat (2) @(negedge clk);
        bus_chk("w1c_collide", OFF_STATUS, 4'b0001, 32'h80, 32'h0000_0000);
        bus_chk("status7_kept", OFF_STATUS, 4'b0000, 32'h0, 32'h0000_0080);
        check("irq_fall7", 32'(irq), 32'd1);
        bus_chk("status_w1c7", OFF_STATUS, 4'b0001, 32'h80, 32'h0000_0080);

        // Reset in the middle of an access.
        bus_chk("oe_ff_wr", OFF_OE, 4'b0001, 32'hFF, 32'h0000_000F);
        check("pin_oe_ff", 32'(pin_oe), 32'h0000_00FF);
        iomem_valid = 1'b1;
        iomem_addr  = ra(OFF_OUT);
        iomem_wstrb = 4'b0000;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_pin_oe", 32'(pin_oe), 32'd0);
        check("mid_rst_pin_do", 32'(pin_do), 32'd0);
        check("mid_rst_ready", 32'(iomem_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        iomem_valid = 1'b0;
        seen        = 0;
        repeat (4) begin
            @(posedge clk); #1;
            seen |= iomem_ready;
        end
        check("no_ready_after_rst", 32'(seen), 32'd0);
        @(negedge clk);

        // Pins high through reset release with RISE_EN written immediately: no edge.
        reset  = 1'b1;
        pin_di = 8'hFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus_chk("prime_rise_en", OFF_RISE_EN, 4'b0001, 32'hFF, 32'h0);
        repeat (6) @(negedge clk);
        check("prime_irq", 32'(irq), 32'd0);
        bus_chk("prime_status", OFF_STATUS, 4'b0000, 32'h0, 32'h0000_0000);
        bus_chk("prime_in", OFF_IN, 4'b0000, 32'h0, 32'h0000_00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
